func1_solver: RTL and testbench

//  Inverse-direction companion to the combinational func1 block (y = ~((a&b&c)|d)).

---
 rtl/func1_solver_if.sv | 28 ++
 rtl/func1_solver.sv | 108 ++++++++++
 tb/tb_func1_solver.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/func1_solver_if.sv
// Handshake and result bus for func1_solver.
//   master : drives start/target, observes status and results (bench side)
//   slave  : receives start/target, drives ready/busy/done/found/sol_*/match_cnt
interface func1_solver_if #(
   parameter int unsigned N = 2
);
   logic           start;
   logic [N-1:0]   target;
   logic           ready;
   logic           busy;
   logic           done;
   logic           found;
   logic [N-1:0]   sol_a;
   logic [N-1:0]   sol_b;
   logic [N-1:0]   sol_c;
   logic [N-1:0]   sol_d;
   logic [4*N:0]   match_cnt;

   modport master (
      output start, target,
      input  ready, busy, done, found, sol_a, sol_b, sol_c, sol_d, match_cnt
   );

   modport slave (
      input  start, target,
      output ready, busy, done, found, sol_a, sol_b, sol_c, sol_d, match_cnt
   );
endinterface

// File: rtl/func1_solver.sv
// Exhaustive inverse solver for y = ~((a&b&c)|d).
// For a latched target it walks every {a,b,c,d} (a in MSBs), one per cycle,
// reporting the lowest-index solution and the total number of solutions.
// Ports:
//   clk  : clock, all state on rising edge
//   rst  : asynchronous active-high reset
//   bus  : func1_solver_if slave (start/target in; ready/busy/done/found/sol_*/match_cnt out)
module func1_solver #(
   parameter int unsigned N = 2
) (
   input  logic          clk,
   input  logic          rst,
   func1_solver_if.slave bus
);

   localparam int unsigned IW = 4 * N;
   localparam int unsigned CW = 4 * N + 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEARCH = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t          state;
   logic [IW-1:0]   idx;
   logic [N-1:0]    tgt;
   logic            last;    // final candidate evaluated; finish on the next edge

   logic [N-1:0]    cand_a;
   logic [N-1:0]    cand_b;
   logic [N-1:0]    cand_c;
   logic [N-1:0]    cand_d;
   logic [N-1:0]    y_c;
   logic            match_c;

   // Candidate decode and func1 evaluation
   assign cand_a  = idx[IW-1 -: N];
   assign cand_b  = idx[3*N-1 -: N];
   assign cand_c  = idx[2*N-1 -: N];
   assign cand_d  = idx[N-1:0];
   assign y_c     = ~((cand_a & cand_b & cand_c) | cand_d);
   assign match_c = (y_c == tgt);

   // Search FSM with registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         idx           <= '0;
         tgt           <= '0;
         last          <= 1'b0;
         bus.ready     <= 1'b1;
         bus.busy      <= 1'b0;
         bus.done      <= 1'b0;
         bus.found     <= 1'b0;
         bus.sol_a     <= '0;
         bus.sol_b     <= '0;
         bus.sol_c     <= '0;
         bus.sol_d     <= '0;
         bus.match_cnt <= '0;
      end else begin
         bus.done <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (bus.start) begin
                  tgt           <= bus.target;
                  idx           <= '0;
                  last          <= 1'b0;
                  bus.match_cnt <= '0;
                  bus.found     <= 1'b0;
                  bus.sol_a     <= '0;
                  bus.sol_b     <= '0;
                  bus.sol_c     <= '0;
                  bus.sol_d     <= '0;
                  bus.ready     <= 1'b0;
                  bus.busy      <= 1'b1;
                  state         <= SEARCH;
               end
            end
            SEARCH: begin
               if (last) begin
                  // idx has already wrapped; no evaluation in this cycle
                  last      <= 1'b0;
                  bus.ready <= 1'b1;
                  bus.busy  <= 1'b0;
                  bus.done  <= 1'b1;
                  state     <= DONE;
               end else begin
                  if (match_c) begin
                     bus.match_cnt <= bus.match_cnt + CW'(1);
                     if (!bus.found) begin
                        bus.found <= 1'b1;
                        bus.sol_a <= cand_a;
                        bus.sol_b <= cand_b;
                        bus.sol_c <= cand_c;
                        bus.sol_d <= cand_d;
                     end
                  end
                  idx <= idx + IW'(1);
                  if (idx == {IW{1'b1}}) last <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_func1_solver.sv
// Self-checking bench for func1_solver: directed targets, back-to-back start,
// mid-search disturbance, reset abort and randomized runs against a
// brute-force reference model.
module tb_func1_solver;

   localparam int unsigned N     = 2;
   localparam int unsigned SPACE = 1 << (4 * N);
   localparam int unsigned LAT   = SPACE + 1;   // edges from acceptance to done

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_err;

   func1_solver_if #(.N(N)) bus ();

   func1_solver #(.N(N)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference func1 on plain integers
   function automatic int f1(input int a, input int b, input int c, input int d);
      return (~((a & b & c) | d)) & ((1 << N) - 1);
   endfunction

   // Brute-force model: count and lowest-index solution for target t
   function automatic void model(input int t, output int cnt, output int first);
      int a, b, c, d;
      cnt   = 0;
      first = -1;
      for (int i = 0; i < int'(SPACE); i++) begin
         a = i / (1 << (3 * N));
         b = (i / (1 << (2 * N))) % (1 << N);
         c = (i / (1 << N)) % (1 << N);
         d = i % (1 << N);
         if (f1(a, b, c, d) == t) begin
            cnt++;
            if (first < 0) first = i;
         end
      end
   endfunction

   function automatic int sol_idx();
      return (int'(bus.sol_a) << (3 * N)) | (int'(bus.sol_b) << (2 * N)) |
             (int'(bus.sol_c) << N) | int'(bus.sol_d);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Assert start for one edge and check acceptance
   task automatic launch(input int t);
      bus.start  = 1'b1;
      bus.target = N'(t);
      step();
      bus.start  = 1'b0;
      n_cmp++;
      if (bus.ready !== 1'b0 || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
         n_err++;
         $display("FAIL launch: ready=%b busy=%b done=%b, required 0 1 0",
                  bus.ready, bus.busy, bus.done);
      end
   endtask

   // Wait for done, checking latency, busy window and results
   task automatic wait_done(input int t, input bit disturb);
      int n, bad_busy, exp_cnt, exp_first, s;
      bit seen;
      n = 0; bad_busy = 0; seen = 1'b0;
      while (n < int'(LAT) + 20 && !seen) begin
         if (disturb) begin
            bus.start  = 1'($urandom);
            bus.target = N'($urandom);
         end
         step();
         n++;
         if (bus.done === 1'b1) seen = 1'b1;
         else if (bus.busy !== 1'b1 || bus.ready !== 1'b0) bad_busy++;
      end
      bus.start = 1'b0;
      n_cmp++;
      if (!seen || n != int'(LAT)) begin
         n_err++;
         $display("FAIL latency t=%0d: done after %0d edges (seen=%b), required %0d",
                  t, n, seen, LAT);
         return;
      end
      n_cmp++;
      if (bad_busy != 0 || bus.busy !== 1'b0 || bus.ready !== 1'b1) begin
         n_err++;
         $display("FAIL busy_window t=%0d: %0d bad cycles, busy=%b ready=%b at done, required 0,0,1",
                  t, bad_busy, bus.busy, bus.ready);
      end
      model(t, exp_cnt, exp_first);
      n_cmp++;
      if (int'(bus.match_cnt) != exp_cnt) begin
         n_err++;
         $display("FAIL match_cnt t=%0d: got %0d, required %0d", t, bus.match_cnt, exp_cnt);
      end
      n_cmp++;
      if (bus.found !== (exp_cnt > 0) || (exp_cnt > 0 && sol_idx() != exp_first)) begin
         n_err++;
         $display("FAIL first_sol t=%0d: found=%b idx=%0d, required found=%b idx=%0d",
                  t, bus.found, sol_idx(), exp_cnt > 0, exp_first);
      end
      s = f1(int'(bus.sol_a), int'(bus.sol_b), int'(bus.sol_c), int'(bus.sol_d));
      n_cmp++;
      if (bus.found === 1'b1 && s != t) begin
         n_err++;
         $display("FAIL sol_crosscheck t=%0d: func1(sol)=%0d, required %0d", t, s, t);
      end
   endtask

   // Outputs hold in DONE and done is a single pulse
   task automatic check_hold(input int t, input int cycles);
      logic [4*N:0] cnt0;
      int           idx0;
      logic         f0;
      int           bad;
      cnt0 = bus.match_cnt; idx0 = sol_idx(); f0 = bus.found; bad = 0;
      for (int i = 0; i < cycles; i++) begin
         bus.target = N'($urandom);
         step();
         if (bus.done !== 1'b0 || bus.ready !== 1'b1 || bus.busy !== 1'b0 ||
             bus.match_cnt !== cnt0 || sol_idx() != idx0 || bus.found !== f0) bad++;
      end
      n_cmp++;
      if (bad != 0) begin
         n_err++;
         $display("FAIL hold t=%0d: %0d cycles changed, required 0", t, bad);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      n_cmp++;
      if (bus.ready !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
          bus.found !== 1'b0 || bus.match_cnt !== '0 || sol_idx() != 0) begin
         n_err++;
         $display("FAIL %s: ready=%b busy=%b done=%b found=%b cnt=%0d sol=%0d, required 1 0 0 0 0 0",
                  tag, bus.ready, bus.busy, bus.done, bus.found, bus.match_cnt, sol_idx());
      end
   endtask

   task automatic test_reset();
      check_reset_vals("reset_por");
      launch(0);
      wait_done(0, 1'b0);
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check_reset_vals("reset_async");
      @(posedge clk);
      #1;
      rst = 1'b0;
      check_reset_vals("reset_release");
   endtask

   task automatic test_target3();
      launch(3);
      wait_done(3, 1'b0);
      check_hold(3, 4);
   endtask

   task automatic test_back_to_back();
      launch(0);
      wait_done(0, 1'b0);
      launch(1);            // start while done is high
      wait_done(1, 1'b0);
      step();
   endtask

   task automatic test_disturb();
      launch(2);
      wait_done(2, 1'b1);
      check_hold(2, 2);
   endtask

   task automatic test_reset_abort();
      int dones;
      launch(3);
      repeat (100) step();
      rst = 1'b1;
      #1;
      check_reset_vals("abort_reset");
      step();
      rst = 1'b0;
      dones = 0;
      for (int i = 0; i < int'(LAT) + 10; i++) begin
         step();
         if (bus.done !== 1'b0 || bus.busy !== 1'b0) dones++;
      end
      n_cmp++;
      if (dones != 0) begin
         n_err++;
         $display("FAIL abort_quiet: %0d active cycles after abort, required 0", dones);
      end
      check_reset_vals("abort_idle");
      launch(3);
      wait_done(3, 1'b0);
   endtask

   task automatic test_random();
      int t;
      for (int r = 0; r < 6; r++) begin
         t = int'($urandom_range((1 << N) - 1, 0));
         repeat ($urandom_range(3, 0)) step();
         launch(t);
         wait_done(t, 1'($urandom));
      end
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      bus.start  = 1'b0;
      bus.target = '0;
      rst = 1'b1;
      #1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      test_reset();
      test_target3();
      test_back_to_back();
      test_disturb();
      test_reset_abort();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
